// File: rtl/load_store_unit_if.sv
// Bus between the memory pipeline stage, the load/store unit and data_memory.
// The slave side is the load/store unit; the master side is core + memory.
interface load_store_unit_if;
    // Upstream request handshake
    logic        REQ;
    logic        STORE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] RDATA;
    // Word-only data_memory port (registered read data)
    logic        MEM_WE;
    logic [31:0] MEM_A;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;

    modport slave (
        input  REQ, STORE, FUNCT3, ADDR, WDATA, MEM_RD,
        output BUSY, DONE, ERR, RDATA, MEM_WE, MEM_A, MEM_WD
    );

    modport master (
        output REQ, STORE, FUNCT3, ADDR, WDATA, MEM_RD,
        input  BUSY, DONE, ERR, RDATA, MEM_WE, MEM_A, MEM_WD
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: adapts RISC-V byte/half/word accesses to a word-only,
// big-endian data memory with one-cycle registered read data. Sub-word stores
// are done as read-modify-write. One request in flight at a time.
module load_store_unit (
    input  logic              CLK,
    input  logic              RST_N,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state, state_d;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        accept;
    logic        req_err;

    // Illegal funct3 for the direction, or an access not aligned to its size.
    function automatic logic is_illegal(logic st, logic [2:0] f3, logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        if (st) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 || misaligned;
    endfunction

    // Big-endian lane select plus sign/zero extension of a loaded word.
    function automatic logic [31:0] extract(logic [2:0] f3, logic [1:0] off, logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // Replace only the addressed byte/half lane of the word read back.
    function automatic logic [31:0] merge(logic [2:0] f3, logic [1:0] off, logic [31:0] word, logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (f3 == F3_H) begin
            if (off[1]) m[15:0]  = wd;
            else        m[31:16] = wd;
        end else begin
            case (off)
                2'd0:    m[31:24] = wd[7:0];
                2'd1:    m[23:16] = wd[7:0];
                2'd2:    m[15:8]  = wd[7:0];
                default: m[7:0]   = wd[7:0];
            endcase
        end
        return m;
    endfunction

    assign accept  = bus.REQ && (state == IDLE);
    assign req_err = is_illegal(bus.STORE, bus.FUNCT3, bus.ADDR[1:0]);

    // Next state and next values of every registered output.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d  = state;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_d = 1'b0;
        mem_wd_d = 32'h0;
        rdata_d  = rdata_q;
        mem_a_d  = mem_a_q;
        case (state)
            IDLE: begin
                if (bus.REQ) begin
                    if (req_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_a_d = {bus.ADDR[31:2], 2'b00};
                        if (bus.STORE && (bus.FUNCT3 == F3_W)) begin
                            state_d  = WRITE;
                            mem_we_d = 1'b1;
                            mem_wd_d = bus.WDATA;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                if (!store_q) begin
                    rdata_d = extract(funct3_q, off_q, bus.MEM_RD);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // The write-data register doubles as the merge register.
                    mem_wd_d = merge(funct3_q, off_q, bus.MEM_RD, wdata_q);
                    mem_we_d = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and registered outputs, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!RST_N) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mem_we_q <= 1'b0;
            rdata_q  <= 32'h0;
            mem_a_q  <= 32'h0;
            mem_wd_q <= 32'h0;
        end else begin
            state    <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mem_we_q <= mem_we_d;
            rdata_q  <= rdata_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
        end
    end

    // Request fields latched at acceptance for use in later states.
    always_ff @(posedge CLK) begin
        // NOTE: pure datapath capture, only read after an acceptance, so no reset is needed.
        if (accept) begin
            store_q  <= bus.STORE;
            funct3_q <= bus.FUNCT3;
            off_q    <= bus.ADDR[1:0];
            wdata_q  <= bus.WDATA[15:0];
        end
    end

    assign bus.BUSY   = (state != IDLE);
    assign bus.DONE   = done_q;
    assign bus.ERR    = err_q;
    assign bus.RDATA  = rdata_q;
    assign bus.MEM_WE = mem_we_q;
    assign bus.MEM_A  = mem_a_q;
    assign bus.MEM_WD = mem_wd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle sequences
// (reset mid-RMW, handshake, back-to-back), then random ops vs a byte-lane model.
module tb_load_store_unit;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    load_store_unit_if bus();

    load_store_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- data_memory model (registered RD) ----------------
    logic [31:0] mem [int];

    function automatic logic [31:0] init_word(int i);
        return 32'hA5A50000 ^ 32'(i);
    endfunction

    function automatic logic [31:0] mem_rd(int i);
        return mem.exists(i) ? mem[i] : init_word(i);
    endfunction

    always @(posedge CLK) begin : mem_model
        int idx;
        idx = int'(bus.MEM_A[11:2]);
        bus.MEM_RD <= mem_rd(idx);
        if (bus.MEM_WE) mem[idx] = bus.MEM_WD;
    end

    int we_count = 0;
    always @(posedge CLK) if (bus.MEM_WE) we_count++;

    int port_viol = 0;
    always @(negedge CLK)
        if ((!bus.MEM_WE && bus.MEM_WD != 32'h0) || bus.MEM_A[1:0] != 2'b00) port_viol++;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
    endfunction

    function automatic logic ref_err(logic st, logic [2:0] f3, logic [31:0] a);
        int n;
        logic legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = 1 << f3[1:0];
        return !legal || ((a % n) != 0);
    endfunction

    // Bit position of the lowest bit of an n-byte big-endian field at offset off.
    function automatic int lane_shift(logic [31:0] a, int n);
        return 32 - 8 * (int'(a[1:0]) + n);
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
        int n, sh;
        logic [31:0] v, t;
        n  = 1 << f3[1:0];
        if (n == 4) return word;
        sh = lane_shift(a, n);
        v  = (word >> sh) & ((32'h1 << (8 * n)) - 1);
        if (!f3[2]) begin
            t = v << (32 - 8 * n);
            v = 32'($signed(t) >>> (32 - 8 * n));
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] old, logic [31:0] wd);
        int n, sh;
        logic [31:0] mask;
        n = 1 << f3[1:0];
        if (n == 4) return wd;
        sh   = lane_shift(a, n);
        mask = ((32'h1 << (8 * n)) - 1) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // ---------------- single request driver ----------------
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd, output int wes);
        int we0;
        @(negedge CLK);
        we0 = we_count;
        bus.REQ = 1'b1; bus.STORE = st; bus.FUNCT3 = f3; bus.ADDR = a; bus.WDATA = wd;
        @(posedge CLK);
        lat = 0;
        while (lat < 10) begin
            @(negedge CLK);
            if (lat == 0) bus.REQ = 1'b0;
            lat++;
            if (bus.DONE) break;
        end
        err = bus.ERR;
        rd  = bus.RDATA;
        wes = we_count - we0;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rdata, logic err, int lat);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.rdata = rdata; v.err = err; v.lat = lat;
        return v;
    endfunction

    vec_t vt [$];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, wes;
        logic        err;
        logic [31:0] rd;
        logic        done_seen;
        logic [15:0] done_mask;
        logic [31:0] last_rdata;

        bus.REQ = 1'b0; bus.STORE = 1'b0; bus.FUNCT3 = 3'b0; bus.ADDR = 32'h0; bus.WDATA = 32'h0;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy",   32'(bus.BUSY),   32'h0);
        check("rst_done",   32'(bus.DONE),   32'h0);
        check("rst_err",    32'(bus.ERR),    32'h0);
        check("rst_mem_we", 32'(bus.MEM_WE), 32'h0);
        check("rst_rdata",  bus.RDATA,       32'h0);
        check("rst_mem_a",  bus.MEM_A,       32'h0);
        check("rst_mem_wd", bus.MEM_WD,      32'h0);
        RST_N = 1'b1;

        // ---------- directed vector table ----------
        vt.push_back(mk(1, 3'b010, 32'h100, 32'h11223344, 32'h00000000, 0, 2)); // SW
        vt.push_back(mk(0, 3'b010, 32'h100, 32'h0,        32'h11223344, 0, 3)); // LW
        vt.push_back(mk(1, 3'b010, 32'h200, 32'h80FF7F01, 32'h11223344, 0, 2)); // SW
        vt.push_back(mk(0, 3'b000, 32'h200, 32'h0,        32'hFFFFFF80, 0, 3)); // LB
        vt.push_back(mk(0, 3'b100, 32'h200, 32'h0,        32'h00000080, 0, 3)); // LBU
        vt.push_back(mk(0, 3'b000, 32'h202, 32'h0,        32'h0000007F, 0, 3)); // LB
        vt.push_back(mk(0, 3'b001, 32'h200, 32'h0,        32'hFFFF80FF, 0, 3)); // LH
        vt.push_back(mk(0, 3'b101, 32'h202, 32'h0,        32'h00007F01, 0, 3)); // LHU
        vt.push_back(mk(1, 3'b010, 32'h300, 32'h11223344, 32'h00007F01, 0, 2)); // SW
        vt.push_back(mk(1, 3'b000, 32'h301, 32'hFFFFFFAB, 32'h00007F01, 0, 4)); // SB
        vt.push_back(mk(0, 3'b010, 32'h300, 32'h0,        32'h11AB3344, 0, 3)); // LW
        vt.push_back(mk(1, 3'b001, 32'h302, 32'h1234BEEF, 32'h11AB3344, 0, 4)); // SH
        vt.push_back(mk(0, 3'b010, 32'h300, 32'h0,        32'h11ABBEEF, 0, 3)); // LW
        vt.push_back(mk(0, 3'b010, 32'h402, 32'h0,        32'h11ABBEEF, 1, 1)); // LW misaligned
        vt.push_back(mk(1, 3'b001, 32'h401, 32'h5555,     32'h11ABBEEF, 1, 1)); // SH misaligned
        vt.push_back(mk(0, 3'b011, 32'h400, 32'h0,        32'h11ABBEEF, 1, 1)); // funct3 011
        vt.push_back(mk(1, 3'b100, 32'h400, 32'h0,        32'h11ABBEEF, 1, 1)); // no SBU
        vt.push_back(mk(0, 3'b100, 32'h303, 32'h0,        32'h000000EF, 0, 3)); // LBU last lane

        for (int i = 0; i < vt.size(); i++) begin
            do_op(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, lat, err, rd, wes);
            check($sformatf("vec%0d_lat", i),   32'(lat), 32'(vt[i].lat));
            check($sformatf("vec%0d_err", i),   32'(err), 32'(vt[i].err));
            check($sformatf("vec%0d_rdata", i), rd,       vt[i].rdata);
            check($sformatf("vec%0d_we", i),    32'(wes), (vt[i].st && !vt[i].err) ? 32'd1 : 32'd0);
        end

        // ---------- reset in the middle of an SB ----------
        do_op(1, 3'b010, 32'h500, 32'hCAFEF00D, lat, err, rd, wes);
        @(negedge CLK);
        bus.REQ = 1'b1; bus.STORE = 1'b1; bus.FUNCT3 = 3'b000; bus.ADDR = 32'h500; bus.WDATA = 32'h12;
        @(posedge CLK);
        @(negedge CLK);
        bus.REQ = 1'b0;
        RST_N = 1'b0;
        done_seen = bus.DONE;
        repeat (2) begin
            @(negedge CLK);
            done_seen |= bus.DONE;
        end
        check("midrst_busy",   32'(bus.BUSY),   32'h0);
        check("midrst_err",    32'(bus.ERR),    32'h0);
        check("midrst_mem_we", 32'(bus.MEM_WE), 32'h0);
        check("midrst_rdata",  bus.RDATA,       32'h0);
        check("midrst_mem_a",  bus.MEM_A,       32'h0);
        check("midrst_mem_wd", bus.MEM_WD,      32'h0);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            done_seen |= bus.DONE;
        end
        check("midrst_no_done", 32'(done_seen), 32'h0);
        check("midrst_mem",     mem_rd(32'h500 >> 2), 32'hCAFEF00D);

        // ---------- REQ held with new fields while busy ----------
        @(negedge CLK);
        wes = we_count;
        bus.REQ = 1'b1; bus.STORE = 1'b0; bus.FUNCT3 = 3'b010; bus.ADDR = 32'h100; bus.WDATA = 32'h0;
        @(posedge CLK);
        done_mask = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                bus.STORE = 1'b1; bus.WDATA = 32'hDEADBEEF;
            end
            if (k == 4) bus.REQ = 1'b0;
            if (bus.DONE) begin
                done_mask[k] = 1'b1;
                if (k == 3) check("hold_ld_rdata", bus.RDATA, 32'h11223344);
                check($sformatf("hold_err_k%0d", k), 32'(bus.ERR), 32'h0);
            end
        end
        check("hold_done_mask", 32'(done_mask), 32'h0028);
        check("hold_we_count",  32'(we_count - wes), 32'd1);
        check("hold_sw_mem",    mem_rd(32'h100 >> 2), 32'hDEADBEEF);

        // ---------- back-to-back loads, one per 3 cycles ----------
        @(negedge CLK);
        bus.REQ = 1'b1; bus.STORE = 1'b0; bus.FUNCT3 = 3'b010; bus.ADDR = 32'h300;
        done_mask = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (bus.DONE) begin
                done_mask[k] = 1'b1;
                check($sformatf("b2b_rdata_k%0d", k), bus.RDATA, 32'h11ABBEEF);
            end
            if (k == 9) bus.REQ = 1'b0;
        end
        check("b2b_done_mask", 32'(done_mask), 32'h0248);
        last_rdata = 32'h11ABBEEF;

        // ---------- random ops against the reference model ----------
        for (int i = 0; i < 80; i++) begin
            logic        st, e;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp_rd;
            int          exp_lat, widx;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h600 + 32'($urandom_range(0, 31));
            wd = $urandom;
            widx = int'(a >> 2);
            e = ref_err(st, f3, a);
            exp_rd = last_rdata;
            if (e)                      exp_lat = 1;
            else if (st && f3 == 3'd2)  exp_lat = 2;
            else if (st)                exp_lat = 4;
            else                        exp_lat = 3;
            if (!e && !st) exp_rd = ref_load(f3, a, ref_rd(widx));
            if (!e && st)  ref_mem[widx] = ref_store(f3, a, ref_rd(widx), wd);
            last_rdata = exp_rd;

            do_op(st, f3, a, wd, lat, err, rd, wes);
            check($sformatf("rnd%0d_lat", i),   32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_err", i),   32'(err), 32'(e));
            check($sformatf("rnd%0d_rdata", i), rd,       exp_rd);
            check($sformatf("rnd%0d_we", i),    32'(wes), (st && !e) ? 32'd1 : 32'd0);
            if (st && !e) check($sformatf("rnd%0d_mem", i), mem_rd(widx), ref_rd(widx));
        end

        check("mem_port_rules", 32'(port_viol), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the core's memory pipeline stage and `data_memory`, adapting RISC-V byte/halfword/word loads and stores to the memory's word-only port. `data_memory` writes whole 32-bit words and returns read data one clock after the address (registered RD). The unit therefore performs alignment checks, big-endian lane selection, sign/zero extension on loads, and read-modify-write for SB/SH. It handles one request at a time, using a REQ/BUSY/DONE handshake upstream.

## Interface
Parameters: none; widths are fixed at 32-bit address and data.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- REQ  in  1  request strobe; accepted at an edge where REQ=1 and BUSY=0
- STORE  in  1  1=store, 0=load; sampled at acceptance
- FUNCT3  in  3  RISC-V funct3; sampled at acceptance
- ADDR  in  32  byte address; sampled at acceptance
- WDATA  in  32  store data, low byte/half used for SB/SH; sampled at acceptance
- BUSY  out  1  high while state≠IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; 1=misaligned or illegal FUNCT3
- RDATA  out  32  load result, valid from DONE onward
- MEM_WE  out  1  to data_memory WE
- MEM_A  out  32  to data_memory A; always {addr[31:2],2'b00}
- MEM_WD  out  32  to data_memory WD
- MEM_RD  in  32  from data_memory RD

## Operation
- Legal FUNCT3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - any other value → ERR.
- Misaligned accesses: halfword with ADDR[0]=1; word with ADDR[1:0]≠0.
- Byte order is big-endian within the word. Offset = ADDR[1:0].
  - Byte lanes: offset 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
  - Halfword lanes: offset 0→[31:16], 2→[15:0].
- Loads: LB and LH sign-extend; LBU and LHU zero-extend.
- SB/SH merge: replace only the target lane of the word read with WDATA[7:0] or WDATA[15:0]; all other bytes keep their read value.
- FSM states: IDLE, READ, CAPTURE, WRITE.
  - IDLE, on accept:
    - ERR case → stay IDLE; DONE=1, ERR=1 next cycle; no memory access.
    - SW → WRITE.
    - Any load, SB or SH → READ.
  - READ: MEM_WE=0, MEM_A=aligned address → CAPTURE.
  - CAPTURE: MEM_RD is valid.
    - Load: RDATA←extracted value, DONE←1 → IDLE.
    - SB/SH: merge register←merged word → WRITE.
  - WRITE: MEM_WE=1, MEM_WD=WDATA (SW) or merged word (SB/SH) → IDLE with DONE←1, ERR←0.
- MEM_WD=0 whenever MEM_WE=0.
- RDATA holds its last load value across stores and errors.
- REQ while BUSY=1 is ignored, not queued. The upstream stage holds REQ until it is accepted.

## Timing
- Reset values (RST_N=0 at an edge): state IDLE; BUSY, DONE, ERR, MEM_WE = 0; RDATA, MEM_A, MEM_WD = 0.
- Latency, with the request accepted at edge E0:
  - Error: DONE high in the cycle after E0.
  - SW: memory write at E1; DONE after E1.
  - Load: memory sampled at E1, data captured at E2; DONE and RDATA after E2.
  - SB/SH: read at E1, merge at E2, write at E3; DONE after E3.
- BUSY is low during the DONE cycle, so the next request can be accepted at that cycle's closing edge.
- Back-to-back throughput:
  - loads: 1 per 3 cycles
  - SW: 1 per 2 cycles
  - SB/SH: 1 per 4 cycles
  - errors: 1 per cycle
- Reset mid-operation:
  - Immediate return to IDLE; no DONE.
  - An SB/SH reset before WRITE leaves memory unmodified.
  - A reset at the WRITE edge itself still commits, because memory samples that same edge.
- MEM_A, MEM_WE and MEM_WD come only from registered state. There is no combinational path from REQ to the memory ports.

## Test plan
- Reset: hold RST_N=0 two cycles mid-SB → all outputs 0; memory word unchanged; no DONE.
- SW then LW at 0x100 with WDATA=0x11223344 → SW DONE after 2 edges. LW DONE 3 edges after its acceptance, RDATA=0x11223344, ERR=0.
- Sub-word loads with word 0x80FF7F01 at 0x200:
  - LB 0x200 → 0xFFFFFF80
  - LBU 0x200 → 0x00000080
  - LB 0x202 → 0x0000007F
  - LH 0x200 → 0xFFFF80FF
  - LHU 0x202 → 0x00007F01
- RMW: word 0x11223344 at 0x300.
  - SB 0x301 with WDATA=0xAB → memory 0x11AB3344.
  - Then SH 0x302 with WDATA=0xBEEF → memory 0x11ABBEEF.
  - DONE 4 edges after acceptance; MEM_WE high exactly one cycle.
- Errors:
  - LW 0x402, SH 0x401 and FUNCT3=011 → each gives DONE=1, ERR=1 one cycle later; MEM_WE never asserted; RDATA unchanged.
- Handshake: REQ held high with new fields while BUSY=1 → ignored until BUSY=0. Back-to-back loads complete one per 3 cycles.
